// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: PC enable and IF/ID, ID/EX, EX/MEM buffer
// stall/clear generation for load-use hazards, branch flushes, slow-memory
// wait states, blocking I/O waits and memory-timeout halt.
module pipeline_ctrl #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        ex_MemRead,
    input  logic [4:0]  ex_rd,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic        io_req,
    input  logic        io_confirm,
    output logic        pc_en,
    output logic        ifb_stall,
    output logic        ifb_clear,
    output logic        idb_stall,
    output logic        idb_clear,
    output logic        exb_stall,
    output logic        halted,
    output logic        mem_err,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StIoWait  = 2'd2,
        StHalt    = 2'd3
    } state_e;

    localparam logic [9:0] TimeoutCnt = TIMEOUT[9:0];

    state_e      state_q, state_d;
    logic [9:0]  wait_cnt_q, wait_cnt_d;
    logic        conf_q;
    logic        mem_err_q, mem_err_d;
    logic [15:0] stall_cnt_q;

    logic load_use;
    logic freeze;
    logic rules_from2;  // evaluate RUN rules 2..5 (io wait, branch, hazard, normal)
    logic rules_from3;  // evaluate RUN rules 3..5 (branch, hazard, normal)

    assign load_use = ex_MemRead && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    // Next-state logic and Mealy buffer controls
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_err_d   = mem_err_q;
        freeze      = 1'b0;
        rules_from2 = 1'b0;
        rules_from3 = 1'b0;
        pc_en       = 1'b1;
        ifb_stall   = 1'b0;
        ifb_clear   = 1'b0;
        idb_stall   = 1'b0;
        idb_clear   = 1'b0;
        exb_stall   = 1'b0;

        unique case (state_q)
            StRun: begin
                if (mem_req && !mem_ready) begin
                    freeze     = 1'b1;
                    state_d    = StMemWait;
                    wait_cnt_d = 10'd0;
                end else begin
                    rules_from2 = 1'b1;
                end
            end
            StMemWait: begin
                if (mem_ready) begin
                    // Ready on the timeout cycle still completes the access.
                    rules_from2 = 1'b1;
                    state_d     = StRun;
                end else if (wait_cnt_q == TimeoutCnt) begin
                    freeze    = 1'b1;
                    state_d   = StHalt;
                    mem_err_d = 1'b1;
                end else begin
                    freeze     = 1'b1;
                    wait_cnt_d = wait_cnt_q + 10'd1;
                end
            end
            StIoWait: begin
                // Only a fresh press releases; a level held from entry does not.
                if (io_confirm && !conf_q) begin
                    rules_from3 = 1'b1;
                    state_d     = StRun;
                end else begin
                    freeze = 1'b1;
                end
            end
            StHalt: begin
                freeze = 1'b1;
            end
            default: begin
                freeze = 1'b1;
            end
        endcase

        if (rules_from2 && io_req) begin
            freeze = 1'b1;
            if (state_q == StRun) begin
                state_d = StIoWait;
            end
        end else if (rules_from2 || rules_from3) begin
            if (branch_taken) begin
                ifb_clear = 1'b1;
                idb_clear = 1'b1;
            end else if (load_use) begin
                pc_en     = 1'b0;
                ifb_stall = 1'b1;
                idb_clear = 1'b1;
            end
        end

        if (freeze) begin
            pc_en     = 1'b0;
            ifb_stall = 1'b1;
            idb_stall = 1'b1;
            exb_stall = 1'b1;
            ifb_clear = 1'b0;
            idb_clear = 1'b0;
        end

        // Reset flushes both front buffers and holds the PC.
        if (!rst) begin
            pc_en     = 1'b0;
            ifb_stall = 1'b0;
            idb_stall = 1'b0;
            exb_stall = 1'b0;
            ifb_clear = 1'b1;
            idb_clear = 1'b1;
        end
    end

    // State, wait counter, confirm sampler and sticky error registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StRun;
            wait_cnt_q <= 10'd0;
            conf_q     <= 1'b0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            conf_q     <= io_confirm;
            mem_err_q  <= mem_err_d;
        end
    end

    // Saturating count of PC-held cycles outside HALT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= 16'd0;
        end else if (!pc_en && (state_q != StHalt) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign state     = state_q;
    assign halted    = (state_q == StHalt);
    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central pipeline sequencing controller for the five-stage RISC-V core. It drives the PC write enable and the stall/clear controls of the IF/ID, ID/EX and EX/MEM pipeline buffers. It resolves load-use hazards, taken-branch flushes, slow data-memory wait states and blocking I/O (ecall) waits. It also halts the pipeline on a memory timeout and keeps a saturating stall-cycle counter for debug display.

## Interface
- TIMEOUT, 1023, maximum MEM_WAIT cycles before halting; wait counter is 10 bits wide.
- clk  in  1  core clock; state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  the ID instruction actually reads that source.
- ex_MemRead  in  1  the instruction in EX is a load.
- ex_rd  in  5  destination register of the EX instruction.
- branch_taken  in  1  EX resolved a taken branch or jump.
- mem_req  in  1  MEM stage is accessing a slow (handshaked) address region.
- mem_ready  in  1  slow region has completed the access.
- io_req  in  1  MEM stage holds a blocking input ecall.
- io_confirm  in  1  debounced confirm button level.
- pc_en  out  1  PC register write enable.
- ifb_stall, ifb_clear  out  1 each  IF/ID buffer controls.
- idb_stall, idb_clear  out  1 each  ID/EX buffer controls; clear inserts a bubble.
- exb_stall  out  1  EX/MEM buffer hold.
- halted  out  1  controller is in HALT.
- mem_err  out  1  sticky flag: memory timeout occurred.
- state  out  2  current state: RUN=0, MEM_WAIT=1, IO_WAIT=2, HALT=3.
- stall_cnt  out  16  saturating count of cycles with pc_en=0, excluding HALT.

## Operation
- Freeze means: pc_en=0, ifb_stall=idb_stall=exb_stall=1, all clears 0.
- Outputs are combinational (Mealy) from state, inputs and registers. They are stable before the buffers sample on the falling edge.
- Load-use hazard condition: ex_MemRead and ex_rd≠0 and ((id_use_rs1 and id_rs1==ex_rd) or (id_use_rs2 and id_rs2==ex_rd)).
- In RUN, the first matching rule applies:
  1. mem_req and !mem_ready: freeze; next state MEM_WAIT; wait_cnt←0.
  2. io_req: freeze; next state IO_WAIT.
  3. branch_taken: pc_en=1, ifb_clear=1, idb_clear=1.
  4. Load-use hazard: pc_en=0, ifb_stall=1, idb_clear=1.
  5. Otherwise: pc_en=1; all stalls and clears 0.
- MEM_WAIT:
  - If mem_ready=1: outputs follow the RUN rules 2–5 this cycle; next state RUN.
  - Else, if wait_cnt==TIMEOUT: freeze; next state HALT; mem_err←1.
  - Else: freeze; wait_cnt←wait_cnt+1.
- IO_WAIT:
  - conf_q is io_confirm registered every cycle.
  - On io_confirm & ~conf_q (rising edge): no freeze this cycle (RUN rules 3–5 apply); next state RUN.
  - Otherwise: freeze. A confirm already held high on entry does not release the wait.
- HALT: freeze until reset; halted=1.
- Freeze beats branch_taken. The branch stays held in the frozen EX/MEM path and is acted on after release.
- stall_cnt increments on every rising edge where pc_en=0 and state≠HALT. It saturates at 16'hFFFF.

## Timing
- While rst=0:
  - state=RUN, wait_cnt=0, conf_q=0, mem_err=0, stall_cnt=0, halted=0.
  - Forced outputs: pc_en=0, ifb_clear=idb_clear=1, all stalls 0.
- First cycle after reset release with idle inputs: pc_en=1, all other controls 0.
- Load-use costs exactly 1 cycle. Once the bubble is in EX, the hazard condition drops.
- Branch flush costs 2 cycles: the 2 younger instructions are cleared in one edge.
- MEM_WAIT with TIMEOUT=T: HALT is entered after T+1 MEM_WAIT cycles, i.e. T+2 frozen cycles counting the entry cycle.
- mem_ready asserted in the same cycle as the wait would time out: mem_ready wins, no mem_err.
- Reset asserted mid-MEM_WAIT or mid-IO_WAIT: immediate return to reset values, asynchronously.

## Test plan
- Load-use: ex_MemRead=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for one cycle → exactly 1 cycle of pc_en=0, ifb_stall=1, idb_clear=1; stall_cnt=1.
- Branch and load-use together: branch_taken=1 plus a matching hazard → pc_en=1, ifb_clear=idb_clear=1, ifb_stall=0.
- Slow memory: mem_req=1 with mem_ready low for 3 cycles, then high → 3 frozen cycles, release in the cycle mem_ready=1, state returns to 0; stall_cnt=3.
- Timeout with TIMEOUT=4: mem_ready held low → HALT after 5 MEM_WAIT cycles; halted=1, mem_err=1, state=3. stall_cnt stops changing; reset clears all.
- IO wait: io_req=1 with io_confirm already high → stays frozen. Confirm low then high → release on the rising-edge cycle.
- Asynchronous reset mid-IO_WAIT → state=0 and clears=1 immediately without a clock edge. After release: pc_en=1, stall_cnt=0.
